// File: rtl/b02_linea_serializer.sv
// Parallel-to-serial feeder for the b02 recognizer: a small FIFO in front of an MSB-first
// shifter that drives LINEA one bit per clock, with an optional idle gap after each word.
module b02_linea_serializer #(
  parameter int unsigned WORD_W     = 4,
  parameter int unsigned GAP_BITS   = 0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              nRESET_G,
  input  logic              FLUSH,
  input  logic [WORD_W-1:0] DATA_IN,
  input  logic              DATA_VALID,
  output logic              DATA_READY,
  output logic              LINEA,
  output logic              LINEA_VALID,
  output logic              WORD_DONE,
  output logic              BUSY
);

  localparam int unsigned CntW  = $clog2(WORD_W);
  localparam int unsigned GapW  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FillW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CntW-1:0]  BitLast = CntW'(WORD_W - 1);
  localparam logic [GapW-1:0]  GapLast = GapW'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);
  localparam logic [FillW-1:0] FullLvl = FillW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0]  fill_q, fill_d;
  logic              ready_q, ready_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];

  logic accept, fifo_empty, load_slot, do_pop, do_bypass, do_push;

  always_comb begin
    accept     = DATA_VALID && ready_q && !FLUSH;
    fifo_empty = (fill_q == '0);
    // Cycles in which the shifter is free to take a new word at the coming edge.
    load_slot  = (state_q == StIdle)
              || (state_q == StShift && bit_cnt_q == '0 && GAP_BITS == 0)
              || (state_q == StGap && gap_cnt_q == '0);
    do_pop     = load_slot && !fifo_empty && !FLUSH;
    do_bypass  = load_slot && fifo_empty && accept;
    do_push    = accept && !do_bypass;

    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    unique case (state_q)
      StShift: begin
        if (bit_cnt_q != '0) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q - CntW'(1);
        end else if (GAP_BITS > 0) begin
          state_d   = StGap;
          gap_cnt_d = GapLast;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: ;
    endcase

    if (do_pop || do_bypass) begin
      shift_d   = do_pop ? mem_q[rd_ptr_q] : DATA_IN;
      bit_cnt_d = BitLast;
      state_d   = StShift;
    end

    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    fill_d = fill_q + FillW'(do_push) - FillW'(do_pop);

    if (FLUSH) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      fill_d    = '0;
    end

    ready_d = (fill_d != FullLvl) && !FLUSH;
  end

  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      ready_q   <= ready_d;
    end
  end

  // Storage needs no reset: the fill count alone says which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= DATA_IN;
  end

  assign DATA_READY  = ready_q;
  assign LINEA_VALID = (state_q == StShift);
  assign LINEA       = LINEA_VALID && shift_q[WORD_W-1];
  assign WORD_DONE   = LINEA_VALID && (bit_cnt_q == '0);
  assign BUSY        = (state_q != StIdle) || (fill_q != '0);

endmodule

// File: tb/tb_b02_linea_serializer.sv
// Bench for b02_linea_serializer: two instances (no gap, 3-cycle gap) share stimulus and are
// compared every cycle against a word-queue reference model, plus directed stream checks.
module tb_b02_linea_serializer;

  localparam int Depth = 2;
  localparam int WordW = 4;

  logic       clock;
  logic       nRESET_G;
  logic       FLUSH;
  logic       DATA_VALID;
  logic [3:0] DATA_IN;
  logic [1:0] rdy_o, linea_o, lv_o, done_o, busy_o;

  int n_checks;
  int n_fail;

  // Reference model: pending words, current word with bits left to send, gap cycles left.
  logic [3:0] m_pend [2][Depth];
  logic [3:0] m_cur  [2];
  int         m_cnt  [2];
  int         m_rem  [2];
  int         m_gap  [2];
  bit         m_rdy  [2];
  bit         m_acc  [2];

  b02_linea_serializer #(.WORD_W(4), .GAP_BITS(0), .FIFO_DEPTH(2)) dut0 (
    .clock(clock), .nRESET_G(nRESET_G), .FLUSH(FLUSH), .DATA_IN(DATA_IN),
    .DATA_VALID(DATA_VALID), .DATA_READY(rdy_o[0]), .LINEA(linea_o[0]),
    .LINEA_VALID(lv_o[0]), .WORD_DONE(done_o[0]), .BUSY(busy_o[0])
  );

  b02_linea_serializer #(.WORD_W(4), .GAP_BITS(3), .FIFO_DEPTH(2)) dut1 (
    .clock(clock), .nRESET_G(nRESET_G), .FLUSH(FLUSH), .DATA_IN(DATA_IN),
    .DATA_VALID(DATA_VALID), .DATA_READY(rdy_o[1]), .LINEA(linea_o[1]),
    .LINEA_VALID(lv_o[1]), .WORD_DONE(done_o[1]), .BUSY(busy_o[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_rem[i] = 0;
      m_gap[i] = 0;
      m_rdy[i] = 0;
      m_acc[i] = 0;
    end
  endfunction

  function automatic void model_edge(int i, logic f, logic v, logic [3:0] d);
    int g;
    bit free;
    g = (i == 0) ? 0 : 3;
    free = 0;
    m_acc[i] = 0;
    if (f) begin
      m_cnt[i] = 0;
      m_rem[i] = 0;
      m_gap[i] = 0;
      m_rdy[i] = 0;
      return;
    end
    m_acc[i] = v && m_rdy[i];
    if (m_rem[i] > 1) m_rem[i]--;
    else if (m_rem[i] == 1) begin
      m_rem[i] = 0;
      if (g > 0) m_gap[i] = g;
      else free = 1;
    end
    else if (m_gap[i] > 1) m_gap[i]--;
    else if (m_gap[i] == 1) begin
      m_gap[i] = 0;
      free = 1;
    end
    else free = 1;

    if (free && m_cnt[i] > 0) begin
      m_cur[i] = m_pend[i][0];
      for (int k = 0; k < Depth - 1; k++) m_pend[i][k] = m_pend[i][k+1];
      m_cnt[i]--;
      m_rem[i] = WordW;
      if (m_acc[i]) begin
        m_pend[i][m_cnt[i]] = d;
        m_cnt[i]++;
      end
    end else if (free && m_acc[i]) begin
      m_cur[i] = d;
      m_rem[i] = WordW;
    end else if (m_acc[i]) begin
      m_pend[i][m_cnt[i]] = d;
      m_cnt[i]++;
    end
    m_rdy[i] = (m_cnt[i] != Depth);
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      int r;
      r = m_rem[i];
      check_eq($sformatf("%s.%0d.READY", tag, i), int'(rdy_o[i]), int'(m_rdy[i]));
      check_eq($sformatf("%s.%0d.LINEA_VALID", tag, i), int'(lv_o[i]), int'(r > 0));
      check_eq($sformatf("%s.%0d.LINEA", tag, i), int'(linea_o[i]),
               (r > 0) ? int'(m_cur[i][r-1]) : 0);
      check_eq($sformatf("%s.%0d.WORD_DONE", tag, i), int'(done_o[i]), int'(r == 1));
      check_eq($sformatf("%s.%0d.BUSY", tag, i), int'(busy_o[i]),
               int'(r > 0 || m_gap[i] > 0 || m_cnt[i] > 0));
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model over the next rising edge,
  // then compare at the following falling edge.
  task automatic step(input logic f, input logic v, input logic [3:0] d);
    FLUSH = f;
    DATA_VALID = v;
    DATA_IN = d;
    if (nRESET_G) for (int i = 0; i < 2; i++) model_edge(i, f, v, d);
    @(negedge clock);
    compare_all("cyc");
  endtask

  task automatic apply_reset();
    FLUSH = 0;
    DATA_VALID = 0;
    #2 nRESET_G = 0;
    model_reset();
    #1 compare_all("async_rst");
    check_eq("async_rst_busy", int'(busy_o[0]), 0);
    check_eq("async_rst_lv", int'(lv_o[0]), 0);
    @(negedge clock);
    nRESET_G = 1;
  endtask

  initial begin
    logic [3:0]  w [5];
    logic [3:0]  bits, dmask;
    logic [11:0] stream;
    bit          obs_v [40];
    bit          obs_b [40];
    bit          obs_d [40];
    int          idx, vcnt, first, saw_low, ndone;

    n_checks = 0;
    n_fail = 0;
    FLUSH = 0;
    DATA_VALID = 0;
    DATA_IN = 0;
    nRESET_G = 0;
    model_reset();
    @(negedge clock);
    compare_all("reset");
    nRESET_G = 1;

    // Release then a single word 1001.
    step(0, 0, 4'h0);
    check_eq("rel_ready", int'(rdy_o[0]), 1);
    step(0, 1, 4'b1001);
    vcnt = 0;
    for (int k = 0; k < 4; k++) begin
      bits[3-k]  = linea_o[0];
      dmask[3-k] = done_o[0];
      vcnt += int'(lv_o[0]);
      step(0, 0, 4'h0);
    end
    check_eq("rel_bits", int'(bits), 9);
    check_eq("rel_valid_cycles", vcnt, 4);
    check_eq("rel_done_mask", int'(dmask), 1);
    check_eq("rel_busy_after", int'(busy_o[0]), 0);

    // Back-to-back, no gap.
    repeat (12) step(0, 0, 4'h0);
    w[0] = 4'hA; w[1] = 4'h5; w[2] = 4'hF; w[3] = 4'h0; w[4] = 4'h0;
    idx = 0;
    saw_low = 0;
    for (int c = 0; c < 30; c++) begin
      step(0, idx < 3, w[idx]);
      if (m_acc[0]) idx++;
      obs_v[c] = lv_o[0];
      obs_b[c] = linea_o[0];
      if (!rdy_o[0]) saw_low = 1;
    end
    check_eq("b2b_accepts", idx, 3);
    check_eq("b2b_ready_drop", saw_low, 1);
    first = -1;
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (obs_v[c]) vcnt++;
      if (obs_v[c] && first < 0) first = c;
    end
    check_eq("b2b_total_bits", vcnt, 12);
    stream = '0;
    vcnt = 0;
    if (first >= 0 && first <= 18) begin
      for (int c = 0; c < 12; c++) begin
        stream[11-c] = obs_b[first+c];
        vcnt += int'(obs_v[first+c]);
      end
    end
    check_eq("b2b_stream", int'(stream), 12'hA5F);
    check_eq("b2b_contiguous", vcnt, 12);

    // Gap insertion on the GAP_BITS=3 instance.
    repeat (15) step(0, 0, 4'h0);
    w[0] = 4'hC; w[1] = 4'h3; w[2] = 4'h0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      step(0, idx < 2, w[idx]);
      if (m_acc[1]) idx++;
      obs_v[c] = lv_o[1];
      obs_b[c] = linea_o[1];
      obs_d[c] = done_o[1];
    end
    check_eq("gap_accepts", idx, 2);
    first = -1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      ndone += int'(obs_d[c]);
      if (obs_v[c] && first < 0) first = c;
    end
    check_eq("gap_done_pulses", ndone, 2);
    stream = '0;
    vcnt = 0;
    if (first >= 0 && first <= 19) begin
      for (int c = 0; c < 4; c++) begin
        stream[11-c] = obs_b[first+c];
        stream[3-c]  = obs_b[first+7+c];
        vcnt += int'(obs_v[first+c]) + int'(obs_v[first+7+c]) + ((c < 3) ? int'(!obs_v[first+4+c]) : 0);
      end
    end
    check_eq("gap_stream", int'(stream), 12'hC03);
    check_eq("gap_shape", vcnt, 11);

    // Flush with two words queued behind 9.
    repeat (15) step(0, 0, 4'h0);
    w[0] = 4'h5; w[1] = 4'h9; w[2] = 4'hA; w[3] = 4'hB; w[4] = 4'h0;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx == 4 && m_rem[0] == 3 && m_cur[0] == 4'h9) break;
      step(0, idx < 4, w[idx]);
      if (m_acc[0]) idx++;
    end
    check_eq("flush_setup_fill", m_cnt[0], 2);
    step(1, 1, 4'hC);
    check_eq("flush_lv", int'(lv_o[0]), 0);
    check_eq("flush_linea", int'(linea_o[0]), 0);
    check_eq("flush_done", int'(done_o[0]), 0);
    check_eq("flush_busy", int'(busy_o[0]), 0);
    step(0, 0, 4'h0);
    check_eq("flush_no_accept", int'(busy_o[0]), 0);

    // Mid-word reset, then a normal word.
    repeat (5) step(0, 0, 4'h0);
    step(0, 1, 4'hB);
    step(0, 0, 4'h0);
    apply_reset();
    step(0, 0, 4'h0);
    step(0, 1, 4'h6);
    for (int k = 0; k < 4; k++) begin
      bits[3-k] = linea_o[0];
      step(0, 0, 4'h0);
    end
    check_eq("post_rst_bits", int'(bits), 6);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) < 3) begin
        apply_reset();
      end else begin
        step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60, 4'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/b02_linea_serializer.md
# b02_linea_serializer

Upstream feeder for the b02 serial recognizer. Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. Shifts each word MSB-first onto the single-bit LINEA line, one bit per clock, with an optional idle gap between words. Its LINEA output connects directly to the recognizer's LINEA input on the same clock.

## Interface
- WORD_W, 4, bits per word shifted onto LINEA (≥2)
- GAP_BITS, 0, idle cycles (LINEA=0, LINEA_VALID=0) inserted after each word (0..15)
- FIFO_DEPTH, 2, words held in addition to the shift register (power of 2, ≥2)

Ports:
- clock  in  1  rising-edge clock
- nRESET_G  in  1  asynchronous, active-low reset
- FLUSH  in  1  synchronous clear of FIFO and shifter
- DATA_IN  in  WORD_W  word to serialize
- DATA_VALID  in  1  DATA_IN valid
- DATA_READY  out  1  block can accept a word this cycle
- LINEA  out  1  serial data, registered
- LINEA_VALID  out  1  LINEA carries a data bit this cycle
- WORD_DONE  out  1  one-cycle pulse coincident with the LSB of each word
- BUSY  out  1  shifter or FIFO non-empty

## Operation
- Accept occurs when DATA_VALID && DATA_READY at a rising edge. DATA_READY is a registered signal equal to !(FIFO full) && !FLUSH. It has no combinational path from DATA_VALID.
- FSM states:
  - IDLE: shifter empty.
  - SHIFT: bit counter runs WORD_W-1 down to 0.
  - GAP: gap counter runs GAP_BITS-1 down to 0.
- IDLE, FIFO empty, accept: the word loads straight into the shifter (bypass) and the FSM goes to SHIFT.
- IDLE, FIFO non-empty: pop the head into the shifter, go to SHIFT.
- SHIFT, count 0:
  - GAP_BITS>0: go to GAP.
  - GAP_BITS=0 and FIFO non-empty (or bypass accept with FIFO empty): load the next word, stay in SHIFT.
  - Otherwise: go to IDLE.
- GAP, count 0: same load/IDLE decision as SHIFT with GAP_BITS=0.
- Push and pop in the same edge are legal. The count is unchanged, and ordering is strictly FIFO.
- An accept that is not bypassed writes to the FIFO tail.
- LINEA = shifter MSB in SHIFT, 0 otherwise. LINEA_VALID = 1 only in SHIFT.
- WORD_DONE = 1 in SHIFT when the bit count is 0.
- BUSY = (state≠IDLE) || (FIFO count≠0).
- FLUSH:
  - At the next edge: FIFO count=0, FSM=IDLE, LINEA=0, LINEA_VALID=0.
  - Any in-flight word is dropped and no WORD_DONE is issued.
  - FLUSH takes priority over accept; no word is taken on a FLUSH edge.
- Counters are sized ceil(log2) of their maximum. FIFO pointers wrap modulo FIFO_DEPTH, and the count runs 0..FIFO_DEPTH.

## Timing
- Reset (nRESET_G low, asynchronous):
  - LINEA=0, LINEA_VALID=0, WORD_DONE=0, BUSY=0, DATA_READY=0.
  - FIFO empty, FSM=IDLE.
- DATA_READY rises at the first clock edge after nRESET_G releases.
- Latency: with the block idle and empty, a word accepted at edge E drives bit W-1 on LINEA during cycle E+1. Bit 0 is driven during cycle E+WORD_W, with WORD_DONE high.
- Back-to-back with GAP_BITS=0: LINEA_VALID stays high continuously, and the next MSB follows the previous LSB in the very next cycle.
- With GAP_BITS=G: exactly G cycles of LINEA_VALID=0 separate consecutive words.
- Throughput: one word per WORD_WORD_W+GAP_BITS cycles.
- DATA_READY falls in the cycle after the accept that fills the FIFO. It rises in the cycle after a pop frees an entry.
- Capacity: FIFO_DEPTH+1 words can be outstanding (FIFO plus shifter).
- Reset asserted mid-word: outputs go to their reset values immediately. No partial word resumes.

## Test plan
- **Reset release:** reset release, then one accept of 4'b1001 → DATA_READY=1 one edge after release; LINEA=1,0,0,1 in cycles E+1..E+4; LINEA_VALID high for those 4 cycles; WORD_DONE high only in E+4; BUSY=0 at E+5.
- **Back-to-back:** GAP_BITS=0, words 4'hA, 4'h5, 4'hF held valid continuously → LINEA = 1010 0101 1111 with no idle cycle. DATA_READY drops after the FIFO holds 2 words, and no word is lost or duplicated.
- **Gap insertion:** GAP_BITS=3, two words 4'hC, 4'h3 → LINEA=1100, then 3 cycles with LINEA_VALID=0, then 0011. There are exactly 2 WORD_DONE pulses.
- **Full FIFO:** fill (3 words outstanding), keep DATA_VALID high → no accept while DATA_READY=0. A simultaneous pop and accept at the LSB of word 1 keeps the count at 2, and output order is preserved.
- **FLUSH:** FLUSH asserted during bit 2 of 4'h9 with 2 words queued → next cycle LINEA=0, LINEA_VALID=0, BUSY=0, no WORD_DONE. A DATA_VALID offered on the FLUSH edge is not accepted.
- **Mid-word reset:** nRESET_G pulsed low mid-word → all outputs 0 asynchronously. After release, the next accepted word 4'h6 is emitted as 0110 with normal latency.
